// File: rtl/breakout_to_host_ser.sv
// Serialises synchronised port/button/link-power status as framed, parity-protected beats over a forwarded clock.
// Frames run back to back in continuous mode; in on-change mode they are sent on payload change or heartbeat.
module breakout_to_host_ser #(
  parameter int PORT_W    = 8,
  parameter int BUTTON_W  = 8,
  parameter int LINK_W    = 4,
  parameter int LANES     = 2,
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 2,
  parameter int HEARTBEAT = 1024
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [PORT_W-1:0]   i_port,
  input  logic [BUTTON_W-1:0] i_button,
  input  logic [LINK_W-1:0]   i_link_pow,
  input  logic                i_mode,
  output logic                o_clk,
  output logic [LANES-1:0]    o_q,
  output logic                o_sent
);

  localparam int PW    = PORT_W + BUTTON_W + LINK_W;
  localparam int BEATS = (PW + LANES - 1) / LANES;
  localparam int SW    = BEATS * LANES;
  localparam int DW    = $clog2(2 * CLK_DIV);
  localparam int BW    = $clog2(BEATS + 1);
  localparam int GW    = $clog2(GAP + 1);
  localparam int HW    = $clog2(HEARTBEAT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BEATS_L  = BW'(BEATS);
  localparam logic [GW-1:0] GAP_L    = GW'(GAP);
  localparam logic [HW-1:0] HB_MAX   = HW'(HEARTBEAT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [PW-1:0]    sync1_q, sync2_q;
  logic [1:0]       warm_q;
  logic [DW-1:0]    div_q;
  logic             clk_q;
  logic [2:0]       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [HW-1:0]    hb_q, hb_d, hb_inc;
  logic [SW-1:0]    shift_q, shift_d;
  logic [LANES-1:0] par_q, par_d;
  logic [LANES-1:0] q_q, q_d;
  logic [PW-1:0]    last_q, last_d;
  logic             force_q, force_d;
  logic             sent_q, sent_d;
  logic             tick, rise, sync_ok, changed, hb_due, due;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= {i_link_pow, i_button, i_port};
      sync2_q <= sync1_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
    end
  end

  // Beat boundary is the falling edge of o_clk: data launches there and is sampled on the rise.
  assign tick = (div_q == DIV_LAST);
  assign rise = (div_q == DIV_MID);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick)      clk_q <= 1'b0;
      else if (rise) clk_q <= 1'b1;
    end
  end

  assign sync_ok = (warm_q == 2'd2);
  assign changed = (sync2_q != last_q);
  assign hb_inc  = (hb_q == HB_MAX) ? hb_q : hb_q + HW'(1);
  assign hb_due  = (state_q == S_IDLE) && (hb_inc == HB_MAX);
  assign due     = sync_ok && (force_q || !i_mode || changed || hb_due);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    hb_d    = hb_q;
    shift_d = shift_q;
    par_d   = par_q;
    q_d     = q_q;
    last_d  = last_q;
    force_d = force_q;
    sent_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (due) begin
            state_d = S_START;
            q_d     = '0;
            shift_d = SW'(sync2_q);
            last_d  = sync2_q;
            par_d   = '0;
            hb_d    = '0;
            force_d = 1'b0;
          end else begin
            hb_d = hb_inc;
          end
        end
        S_START: begin
          state_d = S_DATA;
          q_d     = shift_q[LANES-1:0];
          par_d   = par_q ^ shift_q[LANES-1:0];
          shift_d = shift_q >> LANES;
          beat_d  = BW'(1);
        end
        S_DATA: begin
          if (beat_q == BEATS_L) begin
            state_d = S_PARITY;
            q_d     = par_q;
          end else begin
            q_d     = shift_q[LANES-1:0];
            par_d   = par_q ^ shift_q[LANES-1:0];
            shift_d = shift_q >> LANES;
            beat_d  = beat_q + BW'(1);
          end
        end
        S_PARITY: begin
          state_d = S_GAP;
          q_d     = '1;
          sent_d  = 1'b1;
          gap_d   = GW'(1);
        end
        S_GAP: begin
          if (gap_q != GAP_L) begin
            gap_d = gap_q + GW'(1);
          end else if (due) begin
            // Back-to-back start: continuous mode spends no beats in IDLE.
            state_d = S_START;
            q_d     = '0;
            shift_d = SW'(sync2_q);
            last_d  = sync2_q;
            par_d   = '0;
            hb_d    = '0;
            force_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          q_d     = '1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      hb_q    <= '0;
      shift_q <= '0;
      par_q   <= '0;
      q_q     <= '1;
      last_q  <= '1;
      force_q <= 1'b1;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      hb_q    <= hb_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      q_q     <= q_d;
      last_q  <= last_d;
      force_q <= force_d;
      sent_q  <= sent_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_q    = q_q;
  assign o_sent = sent_q;

endmodule

// File: tb/tb_breakout_to_host_ser.sv
// Directed + randomised bench for breakout_to_host_ser: two instances (2 lanes, 3 lanes) decoded at o_clk rises.
module tb_breakout_to_host_ser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] port0, button0, port3, button3;
  logic [3:0] link0, link3;
  logic       mode0, mode3;
  logic       oclk0, oclk3, sent0, sent3;
  logic [1:0] q0;
  logic [2:0] q3;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int sent_cnt0 = 0;
  int sent_cnt3 = 0;
  int frames_done0 = 0;
  bit pend_en, pend_rst, idle_clean;
  logic [7:0] pend_port;
  logic       pend_mode;

  breakout_to_host_ser #(.LANES(2), .CLK_DIV(4), .GAP(2), .HEARTBEAT(8)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_port(port0), .i_button(button0),
    .i_link_pow(link0), .i_mode(mode0), .o_clk(oclk0), .o_q(q0), .o_sent(sent0));

  breakout_to_host_ser #(.LANES(3), .CLK_DIV(4), .GAP(2), .HEARTBEAT(8)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_port(port3), .i_button(button3),
    .i_link_pow(link3), .i_mode(mode3), .o_clk(oclk3), .o_q(q3), .o_sent(sent3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sent0) sent_cnt0 <= sent_cnt0 + 1;
    if (sent3) sent_cnt3 <= sent_cnt3 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lane l carries bits l, l+L, l+2L ...; parity is the XOR of each lane's bits.
  function automatic logic [2:0] model_par(input logic [19:0] p, input int lanes);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 20; i++) r[i % lanes] = r[i % lanes] ^ p[i];
    return r;
  endfunction

  function automatic logic [2:0] cur_q(input int sel);
    return (sel != 0) ? q3 : {1'b0, q0};
  endfunction

  function automatic logic cur_clk(input int sel);
    return (sel != 0) ? oclk3 : oclk0;
  endfunction

  task automatic next_rise(input int sel, output bit ok);
    logic prev, c;
    ok = 1'b0;
    prev = cur_clk(sel);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      c = cur_clk(sel);
      if (!prev && c) begin
        ok = 1'b1;
        break;
      end
      prev = c;
    end
  endtask

  task automatic wait_rises(input int sel, input int n);
    bit r;
    for (int i = 0; i < n; i++) begin
      next_rise(sel, r);
      if (!r) break;
    end
  endtask

  // Finds the next START beat, then collects the DATA and PARITY beats.
  task automatic rx(input int sel, input int max_beats, output logic [20:0] data,
                    output logic [2:0] par, output int t0, output bit ok);
    int L, NB;
    bit r;
    logic [2:0] q, allone;
    L = (sel != 0) ? 3 : 2;
    NB = (sel != 0) ? 7 : 10;
    allone = (sel != 0) ? 3'b111 : 3'b011;
    data = '0;
    par = '0;
    t0 = 0;
    ok = 1'b0;
    idle_clean = 1'b1;
    for (int n = 0; n < max_beats; n++) begin
      next_rise(sel, r);
      if (!r) break;
      q = cur_q(sel);
      if (q == 3'b000) begin
        t0 = cyc;
        ok = 1'b1;
        break;
      end
      if (q != allone) idle_clean = 1'b0;
    end
    if (!ok) return;
    if (sel == 0) chk("sent_per_frame", sent_cnt0, frames_done0);
    for (int b = 0; b < NB; b++) begin
      next_rise(sel, r);
      if (!r) begin
        ok = 1'b0;
        return;
      end
      q = cur_q(sel);
      for (int l = 0; l < L; l++) data[b * L + l] = q[l];
      if (sel == 0 && b == 2 && pend_rst) begin
        rst_n = 1'b0;
        #1;
        chk("rstmid_oclk", oclk0, 0);
        chk("rstmid_q", q0, 2'b11);
        chk("rstmid_sent", sent0, 0);
        pend_rst = 1'b0;
        ok = 1'b0;
        return;
      end
      if (sel == 0 && b == 2 && pend_en) begin
        port0 = pend_port;
        mode0 = pend_mode;
        pend_en = 1'b0;
      end
    end
    next_rise(sel, r);
    if (!r) begin
      ok = 1'b0;
      return;
    end
    par = cur_q(sel) & allone;
    if (sel == 0) frames_done0++;
  endtask

  logic [20:0] d;
  logic [2:0]  p;
  logic [19:0] exp_pl;
  int t, prev, rel, chg, base3;
  bit ok;

  initial begin
    rst_n = 1'b0;
    port0 = 8'hF0; button0 = 8'hAA; link0 = 4'h8; mode0 = 1'b0;
    port3 = 8'h00; button3 = 8'h00; link3 = 4'h0; mode3 = 1'b0;
    pend_en = 1'b0; pend_rst = 1'b0; pend_port = 8'h00; pend_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_oclk", oclk0, 0);
    chk("reset_q", q0, 2'b11);
    chk("reset_sent", sent0, 0);

    // Continuous mode: back-to-back frames every 14 beats.
    rst_n = 1'b1;
    rel = cyc;
    exp_pl = {link0, button0, port0};
    rx(0, 40, d, p, t, ok);
    chk("cont_ok", ok, 1);
    chk("cont_first_start", t - rel, 12);
    chk("cont_payload", d[19:0], 20'h8AAF0);
    chk("cont_parity", p, model_par(exp_pl, 2));
    prev = t;
    for (int k = 0; k < 2; k++) begin
      rx(0, 40, d, p, t, ok);
      chk("cont_ok", ok, 1);
      chk("cont_period", t - prev, 112);
      chk("cont_payload", d[19:0], exp_pl);
      chk("cont_parity", p, 3'b010);
      prev = t;
    end

    // On-change mode: one forced frame, then heartbeat after 8 idle beats.
    wait_rises(0, 2);
    rst_n = 1'b0;
    mode0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    rx(0, 40, d, p, t, ok);
    chk("oc_ok", ok, 1);
    chk("oc_first_start", t - rel, 12);
    chk("oc_payload", d[19:0], exp_pl);
    prev = t;
    rx(0, 40, d, p, t, ok);
    chk("hb_ok", ok, 1);
    chk("hb_period", t - prev, 176);
    chk("hb_quiet", idle_clean, 1);
    chk("hb_payload", d[19:0], exp_pl);
    wait_rises(0, 5);
    link0 = 4'hF;
    chg = cyc;
    exp_pl = {link0, button0, port0};
    rx(0, 40, d, p, t, ok);
    chk("chg_ok", ok, 1);
    chk("chg_latency", (t - chg) <= 120, 1);
    chk("chg_payload", d[19:0], 20'hFAAF0);
    chk("chg_parity", p, model_par(exp_pl, 2));
    prev = t;

    // Mid-frame input/mode changes only affect the following frames.
    link0 = 4'h3;
    pend_en = 1'b1; pend_port = 8'h5A; pend_mode = 1'b0;
    rx(0, 40, d, p, t, ok);
    chk("mid_ok", ok, 1);
    chk("mid_period", t - prev, 112);
    chk("mid_payload_held", d[19:0], 20'h3AAF0);
    chk("mid_parity", p, model_par(20'h3AAF0, 2));
    prev = t;
    exp_pl = {link0, button0, port0};
    rx(0, 40, d, p, t, ok);
    chk("mid_next_period", t - prev, 112);
    chk("mid_next_payload", d[19:0], exp_pl);
    prev = t;
    pend_en = 1'b1; pend_port = 8'h5A; pend_mode = 1'b1;
    rx(0, 40, d, p, t, ok);
    chk("mode0_period", t - prev, 112);
    chk("mode0_payload", d[19:0], exp_pl);
    prev = t;
    rx(0, 40, d, p, t, ok);
    chk("mode1_period", t - prev, 176);
    chk("mode1_payload", d[19:0], exp_pl);

    // Reset during the third DATA beat abandons the frame without o_sent.
    mode0 = 1'b0;
    pend_rst = 1'b1;
    rx(0, 40, d, p, t, ok);
    chk("rstmid_reached", pend_rst, 0);
    repeat (16) @(negedge clk);
    chk("rstmid_no_sent", sent_cnt0, frames_done0);
    rst_n = 1'b1;
    rel = cyc;
    rx(0, 40, d, p, t, ok);
    chk("rstmid_fresh_ok", ok, 1);
    chk("rstmid_fresh_start", t - rel, 12);
    chk("rstmid_fresh_payload", d[19:0], exp_pl);
    chk("rstmid_fresh_parity", p, model_par(exp_pl, 2));
    wait_rises(0, 2);
    chk("sent_total", sent_cnt0, frames_done0);

    // Three lanes, padded final beat, random payloads.
    rst_n = 1'b0;
    port3 = 8'($urandom); button3 = 8'($urandom); link3 = 4'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pl = {link3, button3, port3};
    rx(1, 40, d, p, t, ok);
    chk("l3_ok", ok, 1);
    chk("l3_payload", d[19:0], exp_pl);
    chk("l3_parity", p, model_par(exp_pl, 3));
    chk("l3_pad", d[20], 0);
    base3 = sent_cnt3;
    prev = t;
    for (int k = 0; k < 200; k++) begin
      port3 = 8'($urandom); button3 = 8'($urandom); link3 = 4'($urandom_range(15, 0));
      exp_pl = {link3, button3, port3};
      rx(1, 40, d, p, t, ok);
      chk("l3_ok", ok, 1);
      chk("l3_period", t - prev, 88);
      chk("l3_payload", d[19:0], exp_pl);
      chk("l3_parity", p, model_par(exp_pl, 3));
      chk("l3_pad", d[20], 0);
      prev = t;
    end
    wait_rises(1, 2);
    chk("l3_sent_count", sent_cnt3 - base3, 201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
